fullbridge_deadtime_driver: RTL and testbench

- Downstream stage of the hybrid controller.
- Consumes the switching variable sigma and drives the four full-bridge MOSFET gates.
- Inserts a programmable dead time on every leg transition and enforces a minimum on-time.
- Latches external faults and measures the switching period (clock cycles between successive positive-leg entries) for monitoring.

---
 rtl/fullbridge_deadtime_driver.sv | 143 ++++++++++++++
 tb/tb_fullbridge_deadtime_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fullbridge_deadtime_driver.sv
// Full-bridge gate driver: turns the switching variable sigma into Q1..Q4 gate
// drives with dead time, minimum on-time, latched fault shutdown and period monitor.
module fullbridge_deadtime_driver #(
  parameter int DEAD_TIME = 20,
  parameter int MIN_ON    = 100,
  parameter int PERIOD_W  = 16
) (
  input  logic                i_clock,
  input  logic                i_RESET,
  input  logic                i_sigma,
  input  logic                i_enable,
  input  logic                i_fault,
  output logic [3:0]          o_MOSFET,
  output logic                o_fault,
  output logic [2:0]          o_state,
  output logic [PERIOD_W-1:0] o_period,
  output logic                o_period_valid
);

  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam int OW = $clog2(MIN_ON + 1);

  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TIME - 1);
  localparam logic [OW-1:0] MIN_ON_C  = OW'(MIN_ON);
  localparam logic [OW-1:0] ON_ONE    = OW'(1);

  localparam logic [3:0] GATES_A   = 4'b1001;
  localparam logic [3:0] GATES_B   = 4'b0110;
  localparam logic [3:0] GATES_OFF = 4'b0000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    ON_A    = 3'd2,
    DEAD_AB = 3'd3,
    ON_B    = 3'd4,
    DEAD_BA = 3'd5,
    FAULT   = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        dead_cnt_q, dead_cnt_d;
  logic [OW-1:0]        on_cnt_q, on_cnt_d;
  logic [PERIOD_W-1:0]  per_cnt_q;
  logic                 meas_armed_q;
  logic                 pos_entry;
  logic                 in_leg_a;

  function automatic logic [3:0] gates_for(input state_t s);
    case (s)
      ON_A:    return GATES_A;
      ON_B:    return GATES_B;
      default: return GATES_OFF;
    endcase
  endfunction

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_leg_a = (state_q == ON_A);

  // Next-state: fault beats disable beats sigma handling
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    on_cnt_d   = on_cnt_q;
    if (i_fault) begin
      state_d = FAULT;
    end else if (state_q == FAULT) begin
      state_d = FAULT;
    end else if (!i_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ARM;
          dead_cnt_d = '0;
        end
        ARM, DEAD_AB, DEAD_BA: begin
          // Leaving an all-off phase: the leg follows sigma at the final cycle
          if (dead_cnt_q == DEAD_LAST) begin
            state_d  = i_sigma ? ON_A : ON_B;
            on_cnt_d = ON_ONE;
          end else begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end
        end
        ON_A, ON_B: begin
          if ((i_sigma != in_leg_a) && (on_cnt_q >= MIN_ON_C)) begin
            state_d    = in_leg_a ? DEAD_AB : DEAD_BA;
            dead_cnt_d = '0;
          end else if (on_cnt_q < MIN_ON_C) begin
            on_cnt_d = on_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A return to leg A after a cancelled dead phase is not a new switching cycle
  assign pos_entry = (state_d == ON_A) && ((state_q == ARM) || (state_q == DEAD_BA));

  always_ff @(posedge i_clock) begin
    if (!i_RESET) begin
      state_q        <= IDLE;
      dead_cnt_q     <= '0;
      on_cnt_q       <= '0;
      per_cnt_q      <= '0;
      meas_armed_q   <= 1'b0;
      o_MOSFET       <= GATES_OFF;
      o_fault        <= 1'b0;
      o_period       <= '0;
      o_period_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      dead_cnt_q     <= dead_cnt_d;
      on_cnt_q       <= on_cnt_d;
      o_MOSFET       <= gates_for(state_d);
      o_period_valid <= 1'b0;
      if (state_d == FAULT) begin
        o_fault <= 1'b1;
      end
      if (pos_entry) begin
        per_cnt_q    <= '0;
        meas_armed_q <= 1'b1;
        if (meas_armed_q) begin
          o_period       <= sat_inc(per_cnt_q);
          o_period_valid <= 1'b1;
        end
      end else begin
        per_cnt_q <= sat_inc(per_cnt_q);
        if ((state_d == IDLE) || (state_d == ARM) || (state_d == FAULT)) begin
          meas_armed_q <= 1'b0;
        end
      end
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_fullbridge_deadtime_driver.sv
// Directed bench for fullbridge_deadtime_driver: start-up, square sigma, min-on,
// dead-time glitch, disable and fault scenarios with hand-computed expectations.
module tb_fullbridge_deadtime_driver;

  logic        i_clock;
  logic        i_RESET;
  logic        i_sigma;
  logic        i_enable;
  logic        i_fault;
  logic [3:0]  o_MOSFET;
  logic        o_fault;
  logic [2:0]  o_state;
  logic [15:0] o_period;
  logic        o_period_valid;

  int compared   = 0;
  int mismatched = 0;

  fullbridge_deadtime_driver #(
    .DEAD_TIME(20),
    .MIN_ON   (100),
    .PERIOD_W (16)
  ) dut (
    .i_clock       (i_clock),
    .i_RESET       (i_RESET),
    .i_sigma       (i_sigma),
    .i_enable      (i_enable),
    .i_fault       (i_fault),
    .o_MOSFET      (o_MOSFET),
    .o_fault       (o_fault),
    .o_state       (o_state),
    .o_period      (o_period),
    .o_period_valid(o_period_valid)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic hold(input int cycles, output int n_valid, output int n_change);
    logic [3:0] g0;
    g0 = o_MOSFET;
    n_valid = 0;
    n_change = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (o_period_valid) n_valid++;
      if (o_MOSFET !== g0) n_change++;
    end
  endtask

  task automatic test_reset();
    int n;
    int saw_v;
    i_RESET = 1'b0; i_enable = 1'b1; i_sigma = 1'b1; i_fault = 1'b0;
    repeat (3) tick();
    compared++;
    if (o_MOSFET !== 4'b0000) begin mismatched++; $display("FAIL reset_gates got %b want 0000", o_MOSFET); end
    compared++;
    if (o_fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault got %b want 0", o_fault); end
    compared++;
    if (o_state !== 3'd0) begin mismatched++; $display("FAIL reset_state got %0d want 0", o_state); end
    compared++;
    if (o_period !== 16'd0 || o_period_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_period got %0d/%b want 0/0", o_period, o_period_valid);
    end
    i_RESET = 1'b1;
    tick();
    compared++;
    if (o_state !== 3'd1) begin mismatched++; $display("FAIL start_arm_state got %0d want 1", o_state); end
    n = 0; saw_v = 0;
    while (o_MOSFET === 4'b0000 && n < 100) begin
      n++;
      if (o_period_valid) saw_v = 1;
      tick();
    end
    compared++;
    if (n != 20) begin mismatched++; $display("FAIL start_arm_len got %0d want 20", n); end
    compared++;
    if (o_MOSFET !== 4'b1001 || o_state !== 3'd2) begin
      mismatched++; $display("FAIL start_leg got %b/%0d want 1001/2", o_MOSFET, o_state);
    end
    compared++;
    if (saw_v != 0 || o_period_valid !== 1'b0) begin
      mismatched++; $display("FAIL start_no_valid got %0d/%b want 0/0", saw_v, o_period_valid);
    end
  endtask

  // Drive a sigma edge into a leg whose min-on is satisfied; expect 20 off cycles then the new leg
  task automatic test_leg_change(input logic sig, input logic [3:0] exp_leg, input logic exp_valid,
                                 input int exp_period, input string name);
    int n;
    int saw_v;
    i_sigma = sig;
    tick();
    n = 0; saw_v = 0;
    while (o_MOSFET === 4'b0000 && n < 100) begin
      n++;
      if (o_period_valid) saw_v = 1;
      tick();
    end
    compared++;
    if (n != 20) begin mismatched++; $display("FAIL %s_dead got %0d want 20", name, n); end
    compared++;
    if (o_MOSFET !== exp_leg) begin mismatched++; $display("FAIL %s_leg got %b want %b", name, o_MOSFET, exp_leg); end
    compared++;
    if (o_period_valid !== exp_valid || saw_v != 0) begin
      mismatched++; $display("FAIL %s_valid got %b/%0d want %b/0", name, o_period_valid, saw_v, exp_valid);
    end
    if (exp_valid) begin
      compared++;
      if (o_period !== 16'(exp_period)) begin
        mismatched++; $display("FAIL %s_period got %0d want %0d", name, o_period, exp_period);
      end
    end
  endtask

  task automatic test_square();
    int nv, nc;
    // 179 hold + 21 edge ticks = 200 cycles per half period
    for (int p = 0; p < 2; p++) begin
      hold(179, nv, nc);
      compared++;
      if (nv != 0 || nc != 0) begin mismatched++; $display("FAIL sq_hold_a got v%0d c%0d want 0 0", nv, nc); end
      test_leg_change(1'b0, 4'b0110, 1'b0, 0, "sq_fall");
      hold(179, nv, nc);
      compared++;
      if (nv != 0 || nc != 0) begin mismatched++; $display("FAIL sq_hold_b got v%0d c%0d want 0 0", nv, nc); end
      test_leg_change(1'b1, 4'b1001, 1'b1, 400, "sq_rise");
    end
  endtask

  task automatic test_min_on();
    int nv, nc, n;
    hold(29, nv, nc);
    i_sigma = 1'b0;
    n = 0;
    while (o_MOSFET === 4'b1001 && n < 300) begin
      n++;
      tick();
    end
    // entry + 99 cycles on: 100 - 29 samples remain after the request
    compared++;
    if (n != 71) begin mismatched++; $display("FAIL minon_hold got %0d want 71", n); end
    n = 0;
    while (o_MOSFET === 4'b0000 && n < 100) begin
      n++;
      tick();
    end
    compared++;
    if (n != 20 || o_MOSFET !== 4'b0110) begin
      mismatched++; $display("FAIL minon_dead got %0d/%b want 20/0110", n, o_MOSFET);
    end
    hold(99, nv, nc);
    // ON_A entry 100 + 20 + 100 + 20 cycles after the previous one
    test_leg_change(1'b1, 4'b1001, 1'b1, 240, "minon_back");
  endtask

  task automatic test_glitch();
    int nv, nc, n, saw_v;
    hold(99, nv, nc);
    i_sigma = 1'b0;
    tick();
    compared++;
    if (o_state !== 3'd3) begin mismatched++; $display("FAIL glitch_dead_state got %0d want 3", o_state); end
    n = 0; saw_v = 0;
    while (o_MOSFET === 4'b0000 && n < 100) begin
      n++;
      if (n == 3) i_sigma = 1'b1;
      if (o_period_valid) saw_v = 1;
      tick();
    end
    compared++;
    if (n != 20) begin mismatched++; $display("FAIL glitch_dead got %0d want 20", n); end
    compared++;
    if (o_MOSFET !== 4'b1001) begin mismatched++; $display("FAIL glitch_leg got %b want 1001", o_MOSFET); end
    compared++;
    if (o_period_valid !== 1'b0 || saw_v != 0) begin
      mismatched++; $display("FAIL glitch_valid got %b/%0d want 0/0", o_period_valid, saw_v);
    end
  endtask

  task automatic test_disable();
    int nv, nc, n, saw_v;
    hold(99, nv, nc);
    i_sigma = 1'b0;
    tick();
    hold(4, nv, nc);
    i_enable = 1'b0;
    tick();
    compared++;
    if (o_state !== 3'd0 || o_MOSFET !== 4'b0000) begin
      mismatched++; $display("FAIL disable_idle got %0d/%b want 0/0000", o_state, o_MOSFET);
    end
    hold(5, nv, nc);
    compared++;
    if (o_state !== 3'd0 || nc != 0) begin
      mismatched++; $display("FAIL disable_stay got %0d/c%0d want 0/c0", o_state, nc);
    end
    i_sigma = 1'b1;
    i_enable = 1'b1;
    tick();
    compared++;
    if (o_state !== 3'd1) begin mismatched++; $display("FAIL reen_arm got %0d want 1", o_state); end
    n = 0; saw_v = 0;
    while (o_MOSFET === 4'b0000 && n < 100) begin
      n++;
      tick();
    end
    compared++;
    if (n != 20 || o_MOSFET !== 4'b1001) begin
      mismatched++; $display("FAIL reen_arm_len got %0d/%b want 20/1001", n, o_MOSFET);
    end
    compared++;
    if (o_period_valid !== 1'b0) begin mismatched++; $display("FAIL reen_no_valid got %b want 0", o_period_valid); end
  endtask

  task automatic test_fault();
    int nv, nc, bad;
    hold(99, nv, nc);
    test_leg_change(1'b0, 4'b0110, 1'b0, 0, "flt_pre");
    hold(10, nv, nc);
    i_fault = 1'b1;
    tick();
    i_fault = 1'b0;
    compared++;
    if (o_MOSFET !== 4'b0000 || o_fault !== 1'b1 || o_state !== 3'd6) begin
      mismatched++; $display("FAIL fault_trip got %b/%b/%0d want 0000/1/6", o_MOSFET, o_fault, o_state);
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      i_sigma = ~i_sigma;
      tick();
      if (o_MOSFET !== 4'b0000 || o_fault !== 1'b1 || o_state !== 3'd6) bad++;
    end
    compared++;
    if (bad != 0) begin mismatched++; $display("FAIL fault_latched got %0d bad cycles want 0", bad); end
    i_RESET = 1'b0;
    tick();
    compared++;
    if (o_fault !== 1'b0 || o_state !== 3'd0 || o_MOSFET !== 4'b0000 || o_period !== 16'd0) begin
      mismatched++;
      $display("FAIL fault_clear got %b/%0d/%b/%0d want 0/0/0000/0", o_fault, o_state, o_MOSFET, o_period);
    end
    i_RESET = 1'b1;
  endtask

  initial begin
    test_reset();
    test_square();
    test_min_on();
    test_glitch();
    test_disable();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
